// File: rtl/systolic_array_ws_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_array_ws_if
//  Description : Handshake/bus bundle for the weight-stationary systolic array.
//                The master side is the feature-map/weight producer plus the
//                result sink. The slave side is the array itself.
//  Signals     : start/n_vec     pass control, n_vec sampled on accepted start
//                w_valid/w_ready/w_data      one weight row per beat
//                in_valid/in_ready/in_data   one activation vector per beat
//                out_valid/out_data          result vector, no backpressure
//                busy/done                   pass status, done is a 1-cycle pulse
//  Revision    : 1.0  initial release
// ============================================================================
interface systolic_array_ws_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                        start;
    logic [CNT_WIDTH-1:0]        n_vec;
    logic                        w_valid;
    logic                        w_ready;
    logic [DATA_WIDTH*COLS-1:0]  w_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH*ROWS-1:0]  in_data;
    logic                        out_valid;
    logic [ACC_WIDTH*COLS-1:0]   out_data;
    logic                        busy;
    logic                        done;

    modport master (
        output start, n_vec, w_valid, w_data, in_valid, in_data,
        input  w_ready, in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, n_vec, w_valid, w_data, in_valid, in_data,
        output w_ready, in_ready, out_valid, out_data, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/systolic_array_ws.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_array_ws
//  Description : Parametrised weight-stationary systolic array. Weights are
//                preloaded one row per beat into the PE grid, activations
//                enter skewed by row, partial sums flow down the columns and
//                are deskewed so a whole result vector emerges in one cycle,
//                ROWS+COLS cycles after the vector was accepted.
//  Ports       : clk    clock
//                rst_n  synchronous active-low reset
//                bus    systolic_array_ws_if.slave (handshakes, data, status)
//  Options     : SA_RELU_EN  when defined, negative results are output as 0
//  Revision    : 1.0  initial release
// ============================================================================
module systolic_array_ws #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    systolic_array_ws_if.slave  bus
);
    localparam int DW      = DATA_WIDTH;
    localparam int AW      = ACC_WIDTH;
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    // Valid pipe length: output register adds the last cycle of latency.
    localparam int VLD_LEN = ROWS + COLS - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    logic [RW-1:0]         r_wcnt;
    logic [CNT_WIDTH-1:0]  r_icnt;
    logic [CNT_WIDTH-1:0]  r_nvec;
    logic                  r_w_ready;
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [VLD_LEN-1:0]    r_vld;
    logic                  r_out_valid;
    logic [COLS*AW-1:0]    r_out_data;

    logic                  w_w_acc;
    logic                  w_in_acc;
    logic [ROWS*DW-1:0]    w_a_skew;
    logic [COLS*AW-1:0]    w_y;

    logic [ROWS-1:0][COLS-1:0][DW-1:0] w_act;
    logic [ROWS:0][COLS-1:0][AW-1:0]   w_ps;

    assign w_w_acc  = bus.w_valid  & r_w_ready;
    assign w_in_acc = bus.in_valid & r_in_ready;

    // ------------------------------------------------------------------------
    // Control FSM; all handshake/status outputs are registered alongside it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_icnt     <= '0;
            r_nvec     <= '0;
            r_w_ready  <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= S_LOAD_W;
                        r_nvec    <= bus.n_vec;
                        r_wcnt    <= '0;
                        r_w_ready <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_LOAD_W: begin
                    if (w_w_acc) begin
                        r_wcnt <= r_wcnt + 1'b1;
                        if (r_wcnt == RW'(ROWS - 1)) begin
                            r_w_ready <= 1'b0;
                            r_icnt    <= '0;
                            if (r_nvec == '0) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_state    <= S_COMPUTE;
                                r_in_ready <= 1'b1;
                            end
                        end
                    end
                end
                S_COMPUTE: begin
                    if (w_in_acc) begin
                        r_icnt <= r_icnt + 1'b1;
                        if (r_icnt == r_nvec - 1'b1) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Empty pipe here means the last result is in the output
                    // register this cycle, so done follows it by one cycle.
                    if (r_vld == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Valid bit travels alongside the data so bubbles never produce output.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[VLD_LEN-2:0], w_in_acc};
        end
    end

    // ------------------------------------------------------------------------
    // Input skew: row r is delayed r cycles. Non-accepted beats inject zeros.
    // ------------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign w_a_skew[0 +: DW] = w_in_acc ? bus.in_data[0 +: DW] : '0;
        end else begin : g_delay
            logic [DW-1:0] r_sk [r];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < r; k++) r_sk[k] <= '0;
                end else begin
                    r_sk[0] <= w_in_acc ? bus.in_data[r*DW +: DW] : '0;
                    for (int k = 1; k < r; k++) r_sk[k] <= r_sk[k-1];
                end
            end
            assign w_a_skew[r*DW +: DW] = r_sk[r-1];
        end
        assign w_act[r][0] = w_a_skew[r*DW +: DW];
    end

    // ------------------------------------------------------------------------
    // PE grid: activations move right, partial sums move down.
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_ps_top
        assign w_ps[0][c] = '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe_col
            logic signed [DW-1:0]   r_wt;
            logic signed [AW-1:0]   r_p;
            logic signed [2*DW-1:0] w_prod;

            assign w_prod = $signed(w_act[r][c]) * r_wt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_wt <= '0;
                    r_p  <= '0;
                end else begin
                    if (w_w_acc && (r_wcnt == RW'(r))) begin
                        r_wt <= $signed(bus.w_data[c*DW +: DW]);
                    end
                    // Product is sign-extended to the accumulator width; the
                    // sum wraps naturally at AW bits.
                    r_p <= $signed(w_ps[r][c]) + AW'(w_prod);
                end
            end
            assign w_ps[r+1][c] = r_p;

            // The last column has no right-hand neighbour to feed.
            if (c < COLS - 1) begin : g_fwd
                logic [DW-1:0] r_a;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_a <= '0;
                    end else begin
                        r_a <= w_act[r][c];
                    end
                end
                assign w_act[r][c+1] = r_a;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output deskew: column c is delayed COLS-1-c cycles.
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign w_y[c*AW +: AW] = w_ps[ROWS][c];
        end else begin : g_delay
            logic [AW-1:0] r_ds [D];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) r_ds[k] <= '0;
                end else begin
                    r_ds[0] <= w_ps[ROWS][c];
                    for (int k = 1; k < D; k++) r_ds[k] <= r_ds[k-1];
                end
            end
            assign w_y[c*AW +: AW] = r_ds[D-1];
        end
    end

    // ------------------------------------------------------------------------
    // Output register: loads only with a valid result, otherwise holds.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_vld[VLD_LEN-1];
            if (r_vld[VLD_LEN-1]) begin
                for (int c = 0; c < COLS; c++) begin
`ifdef SA_RELU_EN
                    r_out_data[c*AW +: AW] <= w_y[c*AW + AW - 1] ? '0 : w_y[c*AW +: AW];
`else
                    r_out_data[c*AW +: AW] <= w_y[c*AW +: AW];
`endif
                end
            end
        end
    end

    assign bus.w_ready   = r_w_ready;
    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire
